// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite plotter slice: FSM state encoding,
// frame geometry, default field widths and the ROM address layout.
// The ROM address is {shape, row, col}, shape in the MSBs.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Frame geometry and pixel depth (160x120, 3-bit colour)
   localparam int SPR_SCREEN_W = 160;
   localparam int SPR_SCREEN_H = 120;
   localparam int SPR_CW       = 3;

   // Default coordinate widths and ROM address fields
   localparam int SPR_XW         = 8;
   localparam int SPR_YW         = 7;
   localparam int SPR_COL_BITS   = 2;
   localparam int SPR_ROW_BITS   = 2;
   localparam int SPR_SHAPE_BITS = 3;

   // Width of {shape,row,col}
   function automatic int rom_aw(input int shape_bits, input int row_bits, input int col_bits);
      return shape_bits + row_bits + col_bits;
   endfunction

   localparam int SPR_ROM_AW = rom_aw(SPR_SHAPE_BITS, SPR_ROW_BITS, SPR_COL_BITS);

endpackage

// File: rtl/sprite_plotter_if.sv
// Signal bundle between game logic, the pattern ROM and vga_adapter.
//  slave  : plotter side (takes requests and ROM data, drives plots)
//  master : environment side (game logic + ROM + VGA adapter)
//  start/x0/y0/shape/erase/bg_colour : draw request
//  rom_addr/rom_data                 : synchronous ROM, 1-cycle read latency
//  vga_x/vga_y/vga_colour/vga_plot   : pixel write to vga_adapter
//  busy/done                         : status
interface sprite_plotter_if
   import sprite_pkg::*;
#(
   parameter int XW         = SPR_XW,
   parameter int YW         = SPR_YW,
   parameter int CW         = SPR_CW,
   parameter int SHAPE_BITS = SPR_SHAPE_BITS,
   parameter int AW         = SPR_ROM_AW
) ();

   logic                  start;
   logic [XW-1:0]         x0;
   logic [YW-1:0]         y0;
   logic [SHAPE_BITS-1:0] shape;
   logic                  erase;
   logic [CW-1:0]         bg_colour;
   logic [AW-1:0]         rom_addr;
   logic [CW-1:0]         rom_data;
   logic [XW-1:0]         vga_x;
   logic [YW-1:0]         vga_y;
   logic [CW-1:0]         vga_colour;
   logic                  vga_plot;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, x0, y0, shape, erase, bg_colour, rom_data,
      output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   modport master (
      output start, x0, y0, shape, erase, bg_colour, rom_data,
      input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

endinterface

// File: rtl/regn.sv
// Generic N-bit load-enable register with synchronous active-low reset.
//  R in, Q out, E load enable, Resetn clears, Clock rising edge.
module regn #(
   parameter int N = 8
) (
   input  logic [N-1:0] R,
   input  logic         Resetn,
   input  logic         E,
   input  logic         Clock,
   output logic [N-1:0] Q
);

   always_ff @(posedge Clock) begin
      if (!Resetn)
         Q <= '0;
      else if (E)
         Q <= R;
   end

endmodule

// File: rtl/sprite_addr_gen.sv
// Raster-scan column/row counter for one sprite.
//  clr_i  : zero both counters (wins over en_i)
//  en_i   : advance one pixel; col wraps and carries into row
//  col_o  : current column
//  row_o  : current row
//  last_o : current position is the final pixel (bottom-right)
module sprite_addr_gen #(
   parameter int COL_BITS = 2,
   parameter int ROW_BITS = 2
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                clr_i,
   input  logic                en_i,
   output logic [COL_BITS-1:0] col_o,
   output logic [ROW_BITS-1:0] row_o,
   output logic                last_o
);

   localparam logic [COL_BITS-1:0] COL_MAX = '1;
   localparam logic [ROW_BITS-1:0] ROW_MAX = '1;

   logic [COL_BITS-1:0] col_q, col_d;
   logic [ROW_BITS-1:0] row_q, row_d;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         // col is a power-of-two width, so it wraps to 0 by itself
         col_d = col_q + COL_BITS'(1);
         if (col_q == COL_MAX)
            row_d = row_q + ROW_BITS'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/sprite_plotter.sv
// Draws one sprite from an external multi-shape pattern ROM at (x0,y0).
// A start/busy/done FSM scans the sprite in raster order; a one-stage
// pipeline carries the plot coordinates alongside the 1-cycle ROM read so
// vga_x/vga_y/vga_plot line up with rom_data. Off-screen pixels are
// clipped and (optionally) pixels matching TRANSP_COLOUR are skipped.
//  Clock, Resetn : clock, synchronous active-low reset
//  spr (slave)   : request, ROM port, VGA plot port and status
module sprite_plotter
   import sprite_pkg::*;
#(
   parameter int            XW            = SPR_XW,
   parameter int            YW            = SPR_YW,
   parameter int            CW            = SPR_CW,
   parameter int            COL_BITS      = SPR_COL_BITS,
   parameter int            ROW_BITS      = SPR_ROW_BITS,
   parameter int            SHAPE_BITS    = SPR_SHAPE_BITS,
   parameter int            SCREEN_W      = SPR_SCREEN_W,
   parameter int            SCREEN_H      = SPR_SCREEN_H,
   parameter bit            TRANSP_EN     = 1'b1,
   parameter logic [CW-1:0] TRANSP_COLOUR = '0
) (
   input logic               Clock,
   input logic               Resetn,
   sprite_plotter_if.slave   spr
);

   localparam int LW = XW + YW + SHAPE_BITS + 1;

   // Screen limits at the widened coordinate width so carries clip too
   localparam logic [XW:0] SCR_W = (XW+1)'(SCREEN_W);
   localparam logic [YW:0] SCR_H = (YW+1)'(SCREEN_H);

   state_e state_q, state_d;

   logic                  ld;
   logic                  cnt_clr;
   logic                  cnt_en;
   logic                  last;
   logic [COL_BITS-1:0]   col;
   logic [ROW_BITS-1:0]   row;

   logic [LW-1:0]         org_q;
   logic [XW-1:0]         x0_q;
   logic [YW-1:0]         y0_q;
   logic [SHAPE_BITS-1:0] shape_q;
   logic                  erase_q;

   logic [XW:0]           px;
   logic [YW:0]           py;
   logic                  valid_q, valid_d;
   logic                  onscr_q, onscr_d;
   logic [XW-1:0]         vga_x_q, vga_x_d;
   logic [YW-1:0]         vga_y_q, vga_y_d;
   logic                  transp;

   // Origin, shape and erase captured once per draw
   regn #(.N(LW)) u_org (
      .R      ({spr.x0, spr.y0, spr.shape, spr.erase}),
      .Resetn (Resetn),
      .E      (ld),
      .Clock  (Clock),
      .Q      (org_q)
   );

   assign {x0_q, y0_q, shape_q, erase_q} = org_q;

   sprite_addr_gen #(
      .COL_BITS (COL_BITS),
      .ROW_BITS (ROW_BITS)
   ) u_addr (
      .Clock  (Clock),
      .Resetn (Resetn),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .col_o  (col),
      .row_o  (row),
      .last_o (last)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge Clock) begin
      if (!Resetn)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ld      = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (spr.start) begin
               ld      = 1'b1;
               cnt_clr = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_en = 1'b1;
            if (last)
               state_d = FLUSH;
         end
         // Final ROM read lands here; its plot appears this cycle
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- plot pipeline ----------------
   assign px = {1'b0, x0_q} + (XW+1)'(col);
   assign py = {1'b0, y0_q} + (YW+1)'(row);

   assign valid_d = (state_q == RUN);
   assign onscr_d = (px < SCR_W) && (py < SCR_H);
   assign vga_x_d = px[XW-1:0];
   assign vga_y_d = py[YW-1:0];

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         valid_q <= 1'b0;
         onscr_q <= 1'b0;
         vga_x_q <= '0;
         vga_y_q <= '0;
      end else begin
         valid_q <= valid_d;
         onscr_q <= onscr_d;
         vga_x_q <= vga_x_d;
         vga_y_q <= vga_y_d;
      end
   end

   // Transparency keys off the ROM pixel even when erasing, so erase
   // clears exactly the footprint a normal draw painted.
   assign transp = TRANSP_EN && (spr.rom_data == TRANSP_COLOUR);

   assign spr.rom_addr   = {shape_q, row, col};
   assign spr.vga_x      = vga_x_q;
   assign spr.vga_y      = vga_y_q;
   assign spr.vga_plot   = valid_q & onscr_q & ~transp;
   assign spr.vga_colour = erase_q ? spr.bg_colour : spr.rom_data;
   assign spr.busy       = (state_q != IDLE);
   assign spr.done       = (state_q == DONE);

endmodule
